// File: rtl/vpg_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : vpg_pkg
// Brief    : Shared encodings, colour constants and bar table for the
//            video pattern generator.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package vpg_pkg;

  typedef enum logic [1:0] {
    BG_BLACK = 2'd0,
    BG_BARS  = 2'd1,
    BG_GREY  = 2'd2,
    BG_RAMP  = 2'd3
  } bg_mode_e;

  typedef enum logic [1:0] {
    BOX_RED   = 2'd0,
    BOX_GREEN = 2'd1,
    BOX_BLUE  = 2'd2,
    BOX_NONE  = 2'd3
  } box_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } vpg_state_e;

  localparam logic [23:0] RED     = 24'hFF0000;
  localparam logic [23:0] GREEN   = 24'h00FF00;
  localparam logic [23:0] BLUE    = 24'h0000FF;
  localparam logic [23:0] WHITE   = 24'hFFFFFF;
  localparam logic [23:0] GREY24  = 24'h808080;
  localparam logic [23:0] BLACK   = 24'h000000;
  localparam logic [23:0] YELLOW  = 24'hFFFF00;
  localparam logic [23:0] CYAN    = 24'h00FFFF;
  localparam logic [23:0] MAGENTA = 24'hFF00FF;

  // Entry 0 is the leftmost bar.
  localparam logic [7:0][23:0] BAR_TABLE = {BLACK, BLUE, RED, MAGENTA,
                                            GREEN, CYAN, YELLOW, WHITE};

  function automatic logic [23:0] box_colour(input logic [1:0] sel);
    logic [23:0] c;
    case (box_sel_e'(sel))
      BOX_RED:   c = RED;
      BOX_GREEN: c = GREEN;
      BOX_BLUE:  c = BLUE;
      default:   c = BLACK;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vpg_timing.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : vpg_timing
// Brief    : Pixel/line counters, sync/de decode and IDLE/RUN/STOPPING run
//            control. Decoded outputs are combinational from counter state.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module vpg_timing
  import vpg_pkg::*;
#(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        pixelclk,
  input  logic        reset_n,
  input  logic        i_en,
  output logic [11:0] o_hc,
  output logic [11:0] o_vc,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic        o_first,
  output logic        o_wrap
);

  localparam logic [11:0] c_H_LAST = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] c_V_LAST = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] c_H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] c_V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] c_HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] c_HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] c_VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] c_VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  vpg_state_e  r_state;
  vpg_state_e  w_state_nxt;
  logic [11:0] r_hc;
  logic [11:0] r_vc;
  logic        w_run;
  logic        w_last_h;
  logic        w_wrap;

  always_comb begin
    w_last_h    = (r_hc == c_H_LAST);
    w_wrap      = w_last_h && (r_vc == c_V_LAST);
    w_run       = (r_state != ST_IDLE);
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (i_en) w_state_nxt = ST_RUN;
      ST_RUN:      if (!i_en) w_state_nxt = w_wrap ? ST_IDLE : ST_STOPPING;
      ST_STOPPING: begin
        if (i_en)        w_state_nxt = ST_RUN;
        else if (w_wrap) w_state_nxt = ST_IDLE;
      end
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Counters sit at the origin while idle so the first RUN cycle is (0,0).
  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_hc    <= '0;
      r_vc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (!w_run) begin
        r_hc <= '0;
        r_vc <= '0;
      end else if (w_last_h) begin
        r_hc <= '0;
        r_vc <= w_wrap ? 12'd0 : r_vc + 12'd1;
      end else begin
        r_hc <= r_hc + 12'd1;
      end
    end
  end

  assign o_hc    = r_hc;
  assign o_vc    = r_vc;
  assign o_de    = w_run && (r_hc < c_H_ACT) && (r_vc < c_V_ACT);
  assign o_hsync = (w_run && (r_hc >= c_HS_BEG) && (r_hc < c_HS_END)) ? SYNC_POL : ~SYNC_POL;
  assign o_vsync = (w_run && (r_vc >= c_VS_BEG) && (r_vc < c_VS_END)) ? SYNC_POL : ~SYNC_POL;
  assign o_first = w_run && (r_hc == 12'd0) && (r_vc == 12'd0);
  assign o_wrap  = w_run && w_wrap;

endmodule
`default_nettype wire

// File: rtl/video_pattern_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : video_pattern_gen
// Brief    : Test video source: background pattern plus a solid target box,
//            with the box centre exported. Define VPG_BOUNCE_EN for motion.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module video_pattern_gen
  import vpg_pkg::*;
#(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit SYNC_POL = 1'b0,
  parameter int BOX_W    = 64,
  parameter int BOX_H    = 64,
  parameter int STEP     = 4
) (
  input  logic        pixelclk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [1:0]  bg_mode,
  input  logic [1:0]  box_sel,
  output logic [23:0] o_rgb,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic [11:0] o_hcount,
  output logic [11:0] o_vcount,
  output logic        o_frame_start,
  output logic [11:0] o_box_hc,
  output logic [11:0] o_box_vc
);

  localparam logic [11:0] c_BOX_W  = 12'(BOX_W);
  localparam logic [11:0] c_BOX_H  = 12'(BOX_H);
  localparam logic [11:0] c_HALF_W = 12'(BOX_W / 2);
  localparam logic [11:0] c_HALF_H = 12'(BOX_H / 2);
  localparam logic [11:0] c_BOX_X0 = 12'((H_ACTIVE - BOX_W) / 2);
  localparam logic [11:0] c_BOX_Y0 = 12'((V_ACTIVE - BOX_H) / 2);
  localparam logic [11:0] c_BAR_W  = 12'(H_ACTIVE / 8);

  logic [11:0] w_hc;
  logic [11:0] w_vc;
  logic        w_hsync;
  logic        w_vsync;
  logic        w_de;
  logic        w_first;
  logic        w_wrap;
  logic [11:0] w_box_x;
  logic [11:0] w_box_y;
  logic        w_in_box;
  logic [11:0] w_bar_q;
  logic [2:0]  w_bar_idx;
  logic [23:0] w_bg;
  logic [23:0] w_pix;

  vpg_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .pixelclk (pixelclk),
    .reset_n  (reset_n),
    .i_en     (en),
    .o_hc     (w_hc),
    .o_vc     (w_vc),
    .o_hsync  (w_hsync),
    .o_vsync  (w_vsync),
    .o_de     (w_de),
    .o_first  (w_first),
    .o_wrap   (w_wrap)
  );

`ifdef VPG_BOUNCE_EN
  localparam logic [12:0] c_X_MAX = 13'(H_ACTIVE - BOX_W);
  localparam logic [12:0] c_Y_MAX = 13'(V_ACTIVE - BOX_H);
  localparam logic [12:0] c_STEP  = 13'(STEP);

  logic [11:0] r_box_x;
  logic [11:0] r_box_y;
  logic        r_dx_neg;
  logic        r_dy_neg;
  logic [12:0] w_sum_x;
  logic [12:0] w_sum_y;
  logic [11:0] w_nx;
  logic [11:0] w_ny;
  logic        w_flip_x;
  logic        w_flip_y;

  // Reaching an edge clamps there and reverses that axis.
  always_comb begin
    w_sum_x  = {1'b0, r_box_x} + c_STEP;
    w_sum_y  = {1'b0, r_box_y} + c_STEP;
    w_nx     = w_sum_x[11:0];
    w_ny     = w_sum_y[11:0];
    w_flip_x = 1'b0;
    w_flip_y = 1'b0;
    if (r_dx_neg) begin
      w_nx = r_box_x - c_STEP[11:0];
      if ({1'b0, r_box_x} <= c_STEP) begin
        w_nx     = '0;
        w_flip_x = 1'b1;
      end
    end else if (w_sum_x >= c_X_MAX) begin
      w_nx     = c_X_MAX[11:0];
      w_flip_x = 1'b1;
    end
    if (r_dy_neg) begin
      w_ny = r_box_y - c_STEP[11:0];
      if ({1'b0, r_box_y} <= c_STEP) begin
        w_ny     = '0;
        w_flip_y = 1'b1;
      end
    end else if (w_sum_y >= c_Y_MAX) begin
      w_ny     = c_Y_MAX[11:0];
      w_flip_y = 1'b1;
    end
  end

  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      r_box_x  <= c_BOX_X0;
      r_box_y  <= c_BOX_Y0;
      r_dx_neg <= 1'b0;
      r_dy_neg <= 1'b0;
    end else if (w_wrap) begin
      r_box_x  <= w_nx;
      r_box_y  <= w_ny;
      r_dx_neg <= r_dx_neg ^ w_flip_x;
      r_dy_neg <= r_dy_neg ^ w_flip_y;
    end
  end

  assign w_box_x = r_box_x;
  assign w_box_y = r_box_y;
`else
  assign w_box_x = c_BOX_X0;
  assign w_box_y = c_BOX_Y0;
`endif

  always_comb begin
    w_in_box  = (w_hc >= w_box_x) && (w_hc < w_box_x + c_BOX_W) &&
                (w_vc >= w_box_y) && (w_vc < w_box_y + c_BOX_H);
    w_bar_q   = w_hc / c_BAR_W;
    w_bar_idx = (w_bar_q > 12'd7) ? 3'd7 : w_bar_q[2:0];
    case (bg_mode_e'(bg_mode))
      BG_BARS: w_bg = BAR_TABLE[w_bar_idx];
      BG_GREY: w_bg = GREY24;
      BG_RAMP: w_bg = {3{w_hc[9:2]}};
      default: w_bg = BLACK;
    endcase
    w_pix = (w_in_box && (box_sel != BOX_NONE)) ? box_colour(box_sel) : w_bg;
  end

  // Box centre is reported continuously, independent of run state.
  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      o_rgb         <= '0;
      o_hsync       <= ~SYNC_POL;
      o_vsync       <= ~SYNC_POL;
      o_de          <= 1'b0;
      o_hcount      <= '0;
      o_vcount      <= '0;
      o_frame_start <= 1'b0;
      o_box_hc      <= c_BOX_X0 + c_HALF_W;
      o_box_vc      <= c_BOX_Y0 + c_HALF_H;
    end else begin
      o_rgb         <= w_de ? w_pix : 24'h000000;
      o_hsync       <= w_hsync;
      o_vsync       <= w_vsync;
      o_de          <= w_de;
      o_hcount      <= w_hc;
      o_vcount      <= w_vc;
      o_frame_start <= w_first;
      o_box_hc      <= w_box_x + c_HALF_W;
      o_box_vc      <= w_box_y + c_HALF_H;
    end
  end

endmodule
`default_nettype wire
